// File: rtl/ps2_key_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_pkg
//   Shared definitions for the PS/2 scan-code sequence encoder.
//   - Prefix byte constants (extended, release, pause).
//   - Keyboard response codes that never start a key sequence.
//   - Sequence-assembly state enum.
// ----------------------------------------------------------------------------
package ps2_key_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_REL   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Keyboard responses (ACK, BAT ok, resend, echo, errors/overrun)
   localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;
   localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
   localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
   localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no bytes held
      ST_PFX   = 2'd1,   // holding E0 and/or F0
      ST_PRT   = 2'd2,   // PrintScreen continuation
      ST_PAUSE = 2'd3    // E1 Pause sequence
   } ps2_seq_state_t;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == PS2_RSP_ACK)    || (b == PS2_RSP_BAT)  ||
             (b == PS2_RSP_RESEND) || (b == PS2_RSP_ECHO) ||
             (b == PS2_RSP_ERR0)   || (b == PS2_RSP_ERR1);
   endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// ----------------------------------------------------------------------------
// ps2_seq_timer
//   Idle counter for a partially received scan-code sequence.
//   Ports:
//     i_clk      system clock
//     i_rst_n    asynchronous active-low reset
//     i_run      counting enabled (a sequence is in progress)
//     i_restart  a byte was accepted; counter returns to zero
//     o_expire   high while the counter sits at TIMEOUT and is running
// ----------------------------------------------------------------------------
module ps2_seq_timer #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_restart,
   output logic o_expire
);

   localparam int              LP_W     = $clog2(TIMEOUT + 1);
   localparam logic [LP_W-1:0] LP_LIMIT = LP_W'(TIMEOUT);

   logic [LP_W-1:0] r_count;

   // Saturates at the limit instead of wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (!i_run || i_restart) begin
         r_count <= '0;
      end else if (r_count != LP_LIMIT) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_run && (r_count == LP_LIMIT);

endmodule

// File: rtl/ps2_key_encoder.sv
// ----------------------------------------------------------------------------
// ps2_key_encoder
//   Assembles PS/2 scan bytes into complete make/break sequences (E0/F0
//   prefixes, PrintScreen, Pause) and publishes each as a 65-bit word.
//   Ports:
//     clk_sys     system clock, rising edge
//     reset_n     asynchronous active-low reset
//     byte_valid  one-cycle strobe qualifying byte_data
//     byte_data   received scan byte
//     ps2_key     [64] toggles per event, [63:0] sequence bytes, last in [7:0]
//     key_strobe  one-cycle pulse with each ps2_key update
//     seq_drop    one-cycle pulse when a partial sequence is discarded
// ----------------------------------------------------------------------------
module ps2_key_encoder
   import ps2_key_pkg::*;
#(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [64:0] ps2_key,
   output logic        key_strobe,
   output logic        seq_drop
);

   ps2_seq_state_t r_state, w_state_nxt;

   // The longest sequence (Pause) is 8 bytes and is emitted in the cycle its
   // eighth byte arrives, so at most 7 bytes are ever held between bytes.
   logic [55:0] r_acc, w_acc_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [64:0] r_key;
   logic        r_strobe;
   logic        r_drop;

   logic        w_emit;
   logic [63:0] w_emit_val;
   logic        w_drop;
   logic        w_fresh;
   logic        w_expire;
   logic [55:0] w_shift;
   logic [63:0] w_shift64;

   assign w_shift   = {r_acc[47:0], byte_data};
   assign w_shift64 = {r_acc, byte_data};

   ps2_seq_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk     (clk_sys),
      .i_rst_n   (reset_n),
      .i_run     (r_state != ST_IDLE),
      .i_restart (byte_valid),
      .o_expire  (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_emit_val  = '0;
      w_drop      = 1'b0;
      w_fresh     = 1'b0;

      // A byte takes priority over a timeout expiring in the same cycle.
      if (byte_valid) begin
         case (r_state)
            ST_IDLE: begin
               w_fresh = 1'b1;
            end

            ST_PFX: begin
               if ((byte_data == PS2_EXT) || (byte_data == PS2_PAUSE) ||
                   ((byte_data == PS2_REL) && (r_acc[7:0] == PS2_REL))) begin
                  // Repeated prefix: abandon the partial sequence and let the
                  // byte start a new one.
                  w_drop  = 1'b1;
                  w_fresh = 1'b1;
               end else if (byte_data == PS2_REL) begin
                  // Only reachable with a lone E0 held.
                  w_acc_nxt = w_shift;
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (((r_cnt == 4'd1) && (r_acc[7:0] == PS2_EXT) &&
                             (byte_data == 8'h12)) ||
                            ((r_cnt == 4'd2) && (r_acc[15:0] == {PS2_EXT, PS2_REL}) &&
                             (byte_data == 8'h7C))) begin
                  w_acc_nxt   = w_shift;
                  w_cnt_nxt   = r_cnt + 4'd1;
                  w_state_nxt = ST_PRT;
               end else begin
                  w_emit      = 1'b1;
                  w_emit_val  = w_shift64;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end
            end

            ST_PRT: begin
               // Make: E0 12 | E0 7C        Break: E0 F0 7C | E0 F0 12
               if (((r_cnt == 4'd2) && (byte_data == PS2_EXT)) ||
                   ((r_cnt == 4'd3) && (r_acc[7:0] == 8'h7C) && (byte_data == PS2_EXT)) ||
                   ((r_cnt == 4'd4) && (byte_data == PS2_REL))) begin
                  w_acc_nxt = w_shift;
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (((r_cnt == 4'd3) && (r_acc[7:0] == PS2_EXT) &&
                             (byte_data == 8'h7C)) ||
                            ((r_cnt == 4'd5) && (byte_data == 8'h12))) begin
                  w_emit      = 1'b1;
                  w_emit_val  = w_shift64;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  // Deviating byte is discarded along with the sequence.
                  w_drop      = 1'b1;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end
            end

            ST_PAUSE: begin
               if (r_cnt == 4'd7) begin
                  w_emit      = 1'b1;
                  w_emit_val  = w_shift64;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_acc_nxt = w_shift;
                  w_cnt_nxt = r_cnt + 4'd1;
               end
            end

            default: begin
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else if (w_expire) begin
         w_drop      = 1'b1;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
         w_state_nxt = ST_IDLE;
      end

      // Byte interpreted as the first byte of a sequence.
      if (w_fresh) begin
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
         w_state_nxt = ST_IDLE;
         if (is_ignored(byte_data)) begin
            w_state_nxt = ST_IDLE;
         end else if ((byte_data == PS2_EXT) || (byte_data == PS2_REL)) begin
            w_acc_nxt   = {48'h0, byte_data};
            w_cnt_nxt   = 4'd1;
            w_state_nxt = ST_PFX;
         end else if (byte_data == PS2_PAUSE) begin
            w_acc_nxt   = {48'h0, byte_data};
            w_cnt_nxt   = 4'd1;
            w_state_nxt = ST_PAUSE;
         end else begin
            w_emit     = 1'b1;
            w_emit_val = {56'h0, byte_data};
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_key    <= '0;
         r_strobe <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_strobe <= w_emit;
         r_drop   <= w_drop;
         if (w_emit) begin
            r_key <= {~r_key[64], w_emit_val};
         end
      end
   end

   assign ps2_key    = r_key;
   assign key_strobe = r_strobe;
   assign seq_drop   = r_drop;

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;

   localparam int TIMEOUT = 20;

   logic        clk_sys;
   logic        reset_n;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic [64:0] ps2_key;
   logic        key_strobe;
   logic        seq_drop;

   int n_cmp;
   int n_err;
   int n_strobe;
   int n_drop;
   int s0;
   int d0;
   int lat;

   ps2_key_encoder #(
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .seq_drop   (seq_drop)
   );

   // clock / reset
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // event counters sampled mid-cycle
   initial begin
      n_strobe = 0;
      n_drop   = 0;
   end
   always @(negedge clk_sys) begin
      if (key_strobe) n_strobe++;
      if (seq_drop)   n_drop++;
   end

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive a byte so that the next rising edge samples it; returns 1 time
   // unit after that edge
   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk_sys);
      #1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic mark();
      s0 = n_strobe;
      d0 = n_drop;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      idle(3);
      check("rst_key", ps2_key, 65'h0);
      check("rst_strobe", {64'h0, key_strobe}, 65'h0);
      check("rst_drop", {64'h0, seq_drop}, 65'h0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      idle(2);

      // single-byte make, 1-cycle latency
      mark();
      send_byte(8'h1C);
      check("make_strobe", {64'h0, key_strobe}, 65'h1);
      check("make_key", ps2_key, 65'h1_0000_0000_0000_001C);
      idle(1);
      check("make_strobe_1cyc", {64'h0, key_strobe}, 65'h0);
      idle(1);
      check("make_nstrobe", 65'(n_strobe - s0), 65'd1);

      // release
      send_byte(8'hF0);
      send_byte(8'h1C);
      idle(2);
      check("brk_key", ps2_key, 65'h0_0000_0000_0000_F01C);

      // extended make / break
      send_byte(8'hE0);
      send_byte(8'h75);
      idle(2);
      check("ext_make", ps2_key, 65'h1_0000_0000_0000_E075);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      idle(2);
      check("ext_brk", ps2_key, 65'h0_0000_0000_00E0_F075);
      check("ext_brk_b2", {57'h0, ps2_key[23:16]}, 65'hE0);

      // PrintScreen make and break, one event each
      mark();
      send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);
      idle(2);
      check("prt_make", ps2_key, 65'h1_0000_0000_E012_E07C);
      check("prt_make_n", 65'(n_strobe - s0), 65'd1);
      mark();
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7C);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
      idle(2);
      check("prt_brk", ps2_key, 65'h0_0000_E0F0_7CE0_F012);
      check("prt_brk_n", 65'(n_strobe - s0), 65'd1);

      // Pause, back-to-back bytes
      mark();
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
      idle(2);
      check("pause", ps2_key, 65'h1_E114_77E1_F014_F077);
      check("pause_n", 65'(n_strobe - s0), 65'd1);

      // timeout after a lone prefix
      mark();
      lat = 0;
      send_byte(8'hE0);
      for (int i = 1; i <= TIMEOUT + 10; i++) begin
         @(posedge clk_sys);
         #1;
         if (seq_drop && lat == 0) lat = i;
      end
      check("tmo_latency", 65'(lat), 65'(TIMEOUT + 1));
      check("tmo_ndrop", 65'(n_drop - d0), 65'd1);
      check("tmo_key", ps2_key, 65'h1_E114_77E1_F014_F077);
      check("tmo_nstrobe", 65'(n_strobe - s0), 65'd0);
      send_byte(8'h1C);
      idle(2);
      check("tmo_next", ps2_key, 65'h0_0000_0000_0000_001C);

      // ignored response codes
      mark();
      send_byte(8'hFA);
      send_byte(8'hAA);
      idle(2);
      check("ign_n", 65'(n_strobe - s0), 65'd0);
      check("ign_key", ps2_key, 65'h0_0000_0000_0000_001C);

      // repeated release prefix
      mark();
      send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h1C);
      idle(2);
      check("rep_drop", 65'(n_drop - d0), 65'd1);
      check("rep_key", ps2_key, 65'h1_0000_0000_0000_F01C);

      // byte arriving in the expiry cycle wins over the timeout
      mark();
      send_byte(8'hE0);
      idle(TIMEOUT);
      send_byte(8'h75);
      idle(2);
      check("race_drop", 65'(n_drop - d0), 65'd0);
      check("race_key", ps2_key, 65'h0_0000_0000_0000_E075);

      // deviating PrintScreen byte
      mark();
      send_byte(8'hE0); send_byte(8'h12); send_byte(8'h55);
      idle(2);
      check("prt_dev_drop", 65'(n_drop - d0), 65'd1);
      check("prt_dev_n", 65'(n_strobe - s0), 65'd0);

      // reset mid-sequence
      mark();
      send_byte(8'hE1);
      send_byte(8'h14);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_key", ps2_key, 65'h0);
      idle(2);
      check("mid_rst_drop", 65'(n_drop - d0), 65'd0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      idle(1);
      send_byte(8'h1C);
      idle(2);
      check("post_rst", ps2_key, 65'h1_0000_0000_0000_001C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
